// File: rtl/fir_out_requant.sv
// fir_out_requant: decimates wide signed FIR samples, rounds/shifts/saturates them to a
// narrow sample, and buffers results in a small FIFO drained over valid/ready.
module fir_out_requant #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4,
    parameter int DECIM     = 2,
    parameter int DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [$clog2(DEPTH):0]      fifo_level,
    input  logic                        clr_flags,
    output logic                        sat_flag,
    output logic                        drop_flag,
    output logic [15:0]                 sat_count
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int RW = IN_WIDTH + 1;
    localparam logic signed [RW-1:0] RND  = RW'((2 ** SHIFT) / 2);
    localparam logic signed [RW-1:0] QMAX = RW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0] QMIN = -QMAX - RW'(1);

    logic [PW-1:0]               phase;
    logic                        keep, sat_ev, drop_ev, full, pop, push;
    logic signed [RW-1:0]        r, q;
    logic signed [OUT_WIDTH-1:0] qs;
    logic                        stg_valid;
    logic signed [OUT_WIDTH-1:0] stg_data;
    logic signed [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]               wr_ptr, rd_ptr;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        keep = in_valid && phase == '0;
        r = RW'(in_data) + RND;
        q = r >>> SHIFT;
        sat_ev = keep && (q > QMAX || q < QMIN);
        qs = q > QMAX ? QMAX[OUT_WIDTH-1:0] : q < QMIN ? QMIN[OUT_WIDTH-1:0] : q[OUT_WIDTH-1:0];
        full = fifo_level == (AW + 1)'(DEPTH);
        out_valid = fifo_level != '0;
        pop = out_valid && out_ready;
        push = stg_valid && (!full || pop);
        drop_ev = stg_valid && full && !pop;
        out_data = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase      <= '0;
            stg_valid  <= 1'b0;
            stg_data   <= '0;
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            sat_flag   <= 1'b0;
            drop_flag  <= 1'b0;
            sat_count  <= '0;
        end else begin
            if (in_valid)
                phase <= phase == PW'(DECIM - 1) ? '0 : phase + 1'b1;
            stg_valid <= keep;
            stg_data  <= qs;
            if (push) begin
                mem[wr_ptr] <= stg_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            // A same-cycle event beats clr_flags.
            sat_flag  <= sat_ev | (sat_flag & ~clr_flags);
            drop_flag <= drop_ev | (drop_flag & ~clr_flags);
            sat_count <= sat_ev ? (clr_flags ? 16'd1 : sat_count + {15'd0, sat_count != 16'hFFFF})
                                : clr_flags ? '0 : sat_count;
        end
    end
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: two instances (DECIM=2 and DECIM=1) checked by directed scenarios
// and a randomized run against a queue-based reference model.
module tb_fir_out_requant;
    logic clk = 1'b0;
    logic rst, in_valid, out_ready, clr_flags;
    logic signed [19:0] in_data;
    logic [1:0] ov, sf, df;
    logic signed [7:0] od [2];
    logic [2:0] lvl [2];
    logic [15:0] sc [2];
    int errors = 0, checks = 0;

    int mq [2][$];
    int ph [2], pd [2], mcnt [2];
    bit pv [2], msat [2], mdrop [2];

    always #5 clk = ~clk;

    fir_out_requant #(.IN_WIDTH(20), .OUT_WIDTH(8), .SHIFT(4), .DECIM(2), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .fifo_level(lvl[0]),
        .clr_flags(clr_flags), .sat_flag(sf[0]), .drop_flag(df[0]), .sat_count(sc[0]));

    fir_out_requant #(.IN_WIDTH(20), .OUT_WIDTH(8), .SHIFT(4), .DECIM(1), .DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .fifo_level(lvl[1]),
        .clr_flags(clr_flags), .sat_flag(sf[1]), .drop_flag(df[1]), .sat_count(sc[1]));

    // Round half up, floor-divide by 16, clip to the 8-bit signed range.
    function automatic int requant(input int x, output bit s);
        int q = (x + 8) >>> 4;
        s = q > 127 || q < -128;
        return q > 127 ? 127 : q < -128 ? -128 : q;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int  d    = (i == 0) ? 2 : 1;
            bit  pop  = mq[i].size() > 0 && out_ready;
            bit  drop = pv[i] && mq[i].size() == 4 && !pop;
            bit  kept = in_valid && ph[i] == 0;
            bit  s;
            int  v;
            if (!rst) begin
                mq[i].delete();
                ph[i] = 0; pv[i] = 0; pd[i] = 0; msat[i] = 0; mdrop[i] = 0; mcnt[i] = 0;
            end else begin
                v = requant(int'(in_data), s);
                s = s && kept;
                if (pop) void'(mq[i].pop_front());
                if (pv[i] && !drop) mq[i].push_back(pd[i]);
                if (in_valid) ph[i] = (ph[i] + 1) % d;
                pv[i] = kept;
                pd[i] = v;
                msat[i]  = s || (msat[i] && !clr_flags);
                mdrop[i] = drop || (mdrop[i] && !clr_flags);
                mcnt[i]  = s ? (clr_flags ? 1 : (mcnt[i] < 65535 ? mcnt[i] + 1 : mcnt[i]))
                             : (clr_flags ? 0 : mcnt[i]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || lvl[i] !== 3'd0 || od[i] !== 8'sd0 || sf[i] !== 1'b0 ||
                df[i] !== 1'b0 || sc[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got v=%b lvl=%0d d=%0d sf=%b df=%b sc=%0d want all 0",
                         i, ov[i], lvl[i], od[i], sf[i], df[i], sc[i]);
            end
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_impulse();
        do_reset();
        in_valid = 1'b1; in_data = 20'sd16;
        step();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++; $display("FAIL impulse_lat1: got out_valid=%b want 0", ov[0]);
        end
        in_data = 20'sd0;
        step();
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 8'sd1) begin
            errors++; $display("FAIL impulse_lat2: got v=%b d=%0d want v=1 d=1", ov[0], od[0]);
        end
        step(); step();
        in_valid = 1'b0;
        step();
        checks++;
        if (lvl[0] !== 3'd2 || sf[0] !== 1'b0) begin
            errors++; $display("FAIL impulse_lvl: got lvl=%0d sf=%b want lvl=2 sf=0", lvl[0], sf[0]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 8'(k == 0 ? 1 : 0)) begin
                errors++; $display("FAIL impulse_out[%0d]: got v=%b d=%0d want %0d", k, ov[0], od[0], k == 0 ? 1 : 0);
            end
            step();
        end
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++; $display("FAIL impulse_empty: got out_valid=%b want 0", ov[0]);
        end
    endtask

    task automatic test_rounding();
        int in_v [4] = '{24, 23, -8, -9};
        int ex_v [4] = '{2, 1, 0, -1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 20'(in_v[k]);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (lvl[1] !== 3'd4) begin
            errors++; $display("FAIL round_lvl: got %0d want 4", lvl[1]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== 8'(ex_v[k])) begin
                errors++; $display("FAIL round[%0d]: got v=%b d=%0d want %0d", k, ov[1], od[1], ex_v[k]);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_data = 20'sd5000;
        step();
        in_data = -20'sd5000;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (sf[1] !== 1'b1 || sc[1] !== 16'd2 || lvl[1] !== 3'd2) begin
            errors++; $display("FAIL sat_flags: got sf=%b sc=%0d lvl=%0d want 1 2 2", sf[1], sc[1], lvl[1]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== 8'(k == 0 ? 127 : -128)) begin
                errors++; $display("FAIL sat_out[%0d]: got v=%b d=%0d want %0d", k, ov[1], od[1], k == 0 ? 127 : -128);
            end
            step();
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        checks++;
        if (sf[1] !== 1'b0 || sc[1] !== 16'd0) begin
            errors++; $display("FAIL sat_clear: got sf=%b sc=%0d want 0 0", sf[1], sc[1]);
        end
    endtask

    task automatic test_decimation();
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            if (n == 4) begin
                in_valid = 1'b0;
                repeat (3) step();
            end
            in_valid = 1'b1; in_data = 20'(16 * n);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (lvl[0] !== 3'd4) begin
            errors++; $display("FAIL decim_lvl: got %0d want 4", lvl[0]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 8'(2 * k + 1)) begin
                errors++; $display("FAIL decim[%0d]: got v=%b d=%0d want %0d", k, ov[0], od[0], 2 * k + 1);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * n);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (lvl[1] !== 3'd4 || df[1] !== 1'b1) begin
            errors++; $display("FAIL bp_full: got lvl=%0d df=%b want 4 1", lvl[1], df[1]);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== 8'(k)) begin
                errors++; $display("FAIL bp_out[%0d]: got v=%b d=%0d want %0d", k, ov[1], od[1], k);
            end
            step();
        end
        checks++;
        if (lvl[1] !== 3'd0 || ov[1] !== 1'b0) begin
            errors++; $display("FAIL bp_empty: got lvl=%0d v=%b want 0 0", lvl[1], ov[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * n);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (lvl[0] !== 3'd3) begin
            errors++; $display("FAIL rmid_pre: got lvl=%0d want 3", lvl[0]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || lvl[0] !== 3'd0 || lvl[1] !== 3'd0) begin
            errors++; $display("FAIL rmid_async: got v=%b lvl0=%0d lvl1=%0d want 0 0 0", ov[0], lvl[0], lvl[1]);
        end
        step();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 20'sd32;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 8'sd2) begin
            errors++; $display("FAIL rmid_phase: got v=%b d=%0d want v=1 d=2", ov[0], od[0]);
        end
    endtask

    task automatic test_random();
        int v;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 1048575)) - 524288;
            else v = int'($urandom_range(0, 6000)) - 3000;
            in_valid  = $urandom_range(0, 9) < 7;
            in_data   = 20'(v);
            out_ready = $urandom_range(0, 1) == 1;
            clr_flags = $urandom_range(0, 29) == 0;
            rst       = c != 400;
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ov[i] !== (mq[i].size() > 0) || int'(lvl[i]) != mq[i].size() ||
                    (mq[i].size() > 0 && int'(od[i]) != mq[i][0]) || sf[i] !== msat[i] ||
                    df[i] !== mdrop[i] || int'(sc[i]) != mcnt[i]) begin
                    errors++;
                    $display("FAIL rand[%0d] c=%0d: got v=%b lvl=%0d d=%0d sf=%b df=%b sc=%0d want lvl=%0d d=%0d sf=%b df=%b sc=%0d",
                             i, c, ov[i], lvl[i], od[i], sf[i], df[i], sc[i], mq[i].size(),
                             mq[i].size() > 0 ? mq[i][0] : 0, msat[i], mdrop[i], mcnt[i]);
                end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
